// File: rtl/fft_reorder_32.sv
// Ping-pong bit-reversal reorder buffer for a 32-point FFT: accepts samples in
// bit-reversed order and replays each completed frame in natural bin order.
module fft_reorder_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [21:0] data_in_real,
    input  logic [21:0] data_in_imag,
    output logic        out_valid,
    output logic [21:0] data_out_real,
    output logic [21:0] data_out_imag,
    output logic [4:0]  out_index,
    output logic        out_last
);

    typedef enum logic {IDLE, READ} state_t;

    // Both banks live in one array; the top address bit selects the bank.
    logic [43:0] mem [0:63];

    logic [4:0] wr_cnt;
    logic       wr_bank;
    logic [4:0] rd_cnt;
    logic       rd_bank;
    logic [1:0] full;
    state_t     state;

    logic        wr_done;
    logic [1:0]  set_full;
    logic [1:0]  clr_full;
    logic        rd_fire;
    logic        rd_done;
    logic        other_ready;
    logic [43:0] rd_word;

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    assign wr_done = in_valid && (wr_cnt == 5'd31);
    assign rd_word = mem[{rd_bank, rd_cnt}];

    always_comb begin
        set_full = 2'b00;
        clr_full = 2'b00;
        if (wr_done) set_full[wr_bank] = 1'b1;
        // rd_cnt is always 0 in IDLE, so starting a frame reads bin 0 on the same edge.
        rd_fire = (state == READ) || full[rd_bank];
        rd_done = rd_fire && (rd_cnt == 5'd31);
        if (rd_done) clr_full[rd_bank] = 1'b1;
        // Look ahead at a frame completing on this very edge so back-to-back frames have no gap.
        other_ready = full[~rd_bank] | set_full[~rd_bank];
    end

    always_ff @(posedge clk) begin
        if (in_valid) mem[{wr_bank, bitrev5(wr_cnt)}] <= {data_in_real, data_in_imag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= 5'd0;
            wr_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            if (in_valid) begin
                wr_cnt <= wr_cnt + 5'd1;
                if (wr_cnt == 5'd31) wr_bank <= ~wr_bank;
            end
            full <= (full | set_full) & ~clr_full;
        end
    end

    // Banks are filled and drained in strict alternation, so rd_bank always
    // names the oldest full bank once it toggles after every drained frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_cnt        <= 5'd0;
            rd_bank       <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_index     <= 5'd0;
            data_out_real <= 22'd0;
            data_out_imag <= 22'd0;
        end else if (rd_fire) begin
            out_valid     <= 1'b1;
            out_last      <= (rd_cnt == 5'd31);
            out_index     <= rd_cnt;
            data_out_real <= rd_word[43:22];
            data_out_imag <= rd_word[21:0];
            rd_cnt        <= rd_cnt + 5'd1;
            if (rd_cnt == 5'd31) begin
                rd_bank <= ~rd_bank;
                state   <= other_ready ? READ : IDLE;
            end else begin
                state   <= READ;
            end
        end else begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_index     <= 5'd0;
            data_out_real <= 22'd0;
            data_out_imag <= 22'd0;
        end
    end

endmodule

// File: tb/tb_fft_reorder_32.sv
// Randomized scoreboard bench for fft_reorder_32: a frame-level reference model
// predicts every output bin and the exact cycle it must appear.
module tb_fft_reorder_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [21:0] data_in_real = '0;
    logic [21:0] data_in_imag = '0;
    logic        out_valid;
    logic [21:0] data_out_real;
    logic [21:0] data_out_imag;
    logic [4:0]  out_index;
    logic        out_last;

    fft_reorder_32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .data_in_real(data_in_real), .data_in_imag(data_in_imag),
        .out_valid(out_valid), .data_out_real(data_out_real),
        .data_out_imag(data_out_imag), .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] re;
        logic [21:0] im;
        int          idx;
        longint      cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [43:0] part[$];
    longint      edge_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < 5; i++) if ((v >> i) & 1) r += 1 << (4 - i);
        return r;
    endfunction

    // Reference model: a frame completes on its 32nd sample; bin n equals the
    // sample that arrived in position bitrev(n), due n+1 edges later.
    task automatic accept(input logic [21:0] re, input logic [21:0] im, input longint e);
        exp_t x;
        part.push_back({re, im});
        if (part.size() == 32) begin
            for (int n = 0; n < 32; n++) begin
                x.re  = part[bitrev(n)][43:22];
                x.im  = part[bitrev(n)][21:0];
                x.idx = n;
                x.cyc = e + 1 + n;
                sbq.push_back(x);
            end
            part.delete();
        end
    endtask

    task automatic step(input logic v, input logic [21:0] re, input logic [21:0] im);
        in_valid = v; data_in_real = re; data_in_imag = im;
        @(posedge clk); #1;
        if (v) accept(re, im, edge_cnt);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 22'd0, 22'd0);
    endtask

    task automatic rand_frame(input int gap_pct);
        for (int k = 0; k < 32; k++) begin
            while ($urandom_range(99) < gap_pct) step(1'b0, $urandom(), $urandom());
            step(1'b1, $urandom(), $urandom());
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_index !== 5'd0 ||
            data_out_real !== 22'd0 || data_out_imag !== 22'd0) begin
            n_err++;
            $display("FAIL %s: got valid=%b last=%b idx=%0d re=%h im=%h, required all zero",
                     name, out_valid, out_last, out_index, data_out_real, data_out_imag);
        end
    endtask

    task automatic do_reset_now();
        rst_n = 1'b0;
        sbq.delete();
        part.delete();
        #1 check_zero("async_reset");
    endtask

    // Monitor: pops on every valid output; also flags outputs that never came.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got idx=%0d re=%h im=%h at edge %0d, required none",
                         out_index, data_out_real, data_out_imag, edge_cnt);
            end else begin
                e = sbq.pop_front();
                if (data_out_real !== e.re || data_out_imag !== e.im || out_index !== e.idx[4:0] ||
                    out_last !== (e.idx == 31) || edge_cnt != e.cyc) begin
                    n_err++;
                    $display("FAIL bin: got idx=%0d re=%h im=%h last=%b edge=%0d, required idx=%0d re=%h im=%h last=%b edge=%0d",
                             out_index, data_out_real, data_out_imag, out_last, edge_cnt,
                             e.idx, e.re, e.im, (e.idx == 31), e.cyc);
                end
            end
        end else begin
            check_zero("idle_outputs");
            if (sbq.size() > 0 && sbq[0].cyc <= edge_cnt) begin
                n_cmp++;
                n_err++;
                e = sbq.pop_front();
                $display("FAIL missing_output: got out_valid=0 at edge %0d, required idx=%0d", edge_cnt, e.idx);
            end
        end
    end

    initial begin
        int w;
        #2 rst_n = 1'b0;
        #1 check_zero("reset_state");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Single frame, sample k = (k, -k)
        for (int k = 0; k < 32; k++) step(1'b1, 22'(k), 22'(-k));
        idle(40);

        // Three back-to-back random frames
        for (int f = 0; f < 3; f++) rand_frame(0);
        idle(40);

        // Every-other-cycle input
        for (int k = 0; k < 32; k++) begin
            step(1'b1, $urandom(), $urandom());
            step(1'b0, 22'd0, 22'd0);
        end
        idle(40);

        // Random duty cycle, several frames
        for (int f = 0; f < 4; f++) rand_frame(30);
        idle(40);

        // Partial frame held through a long pause
        for (int k = 0; k < 10; k++) step(1'b1, $urandom(), $urandom());
        idle(60);
        for (int k = 0; k < 22; k++) step(1'b1, $urandom(), $urandom());
        idle(40);

        // Reset after 20 samples, then one clean frame
        for (int k = 0; k < 20; k++) step(1'b1, $urandom(), $urandom());
        do_reset_now();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        rand_frame(0);
        idle(40);

        // Full-scale extremes
        for (int k = 0; k < 32; k++) begin
            if (k % 2 == 0) step(1'b1, 22'h200000, 22'h1FFFFF);
            else            step(1'b1, 22'h1FFFFF, 22'h200000);
        end
        idle(40);

        // Reset while reading bin 10
        rand_frame(0);
        w = 0;
        while (!(out_valid === 1'b1 && out_index == 5'd10) && w < 100) begin
            @(negedge clk); w++;
        end
        n_cmp++;
        if (w >= 100) begin
            n_err++;
            $display("FAIL wait_bin10: got timeout after %0d cycles, required bin 10 output", w);
        end
        #2 do_reset_now();
        @(posedge clk); #1 rst_n = 1'b1;
        idle(50);
        rand_frame(10);
        idle(40);

        // Drain anything still expected
        for (int i = 0; i < 200 && sbq.size() > 0; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d bins outstanding, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
